// File: rtl/apb_pkg.sv
// apb_pkg: shared widths and FSM state type for the APB byte-memory slave
package apb_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_slv_state_e;
endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: byte memory, sync write, comb read, reset clear; out-of-range reads 0 and drops writes
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_hit;
  assign w_hit = 32'(i_addr) < MEM_DEPTH;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    else if (i_we && w_hit) r_mem[i_addr[IW-1:0]] <= i_wdata;
  end
  assign o_rdata = w_hit ? r_mem[i_addr[IW-1:0]] : '0;
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with IDLE/SETUP/ACCESS FSM, wait states, sticky protocol-error flag
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_DEPTH   = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET_N,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic                  PWAKEUP,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  input  logic                  ERR_CLR,
  output logic                  PROT_ERR
);
  apb_slv_state_e        r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_wait;
  logic                  r_err;
  logic                  w_ready;
  logic                  w_we;
  logic                  w_mismatch;
  logic                  w_viol;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_ready    = r_state == ACCESS && r_wait == 2'(WAIT_STATES);
  assign w_we       = w_ready && PSEL && PENABLE && r_write;
  assign w_mismatch = PADDR != r_addr || PWRITE != r_write || PWDATA != r_wdata;
  // once PSEL drops in ACCESS the requester has left, so only an early drop is an error
  assign w_viol = (r_state == IDLE && PENABLE)
               || (r_state == SETUP && !(PSEL && PENABLE))
               || (r_state == ACCESS && (PSEL ? w_mismatch : !w_ready));
  assign PREADY   = w_ready;
  assign PRDATA   = (w_ready && !r_write) ? w_rdata : '0;
  assign PROT_ERR = r_err;
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_viol | (r_err & ~ERR_CLR);
      case (r_state)
        IDLE: if (PSEL && !PENABLE && PWAKEUP) begin
          r_state <= SETUP;
          r_addr  <= PADDR;
          r_write <= PWRITE;
          r_wdata <= PWDATA;
        end
        SETUP: begin
          r_state <= (PSEL && PENABLE) ? ACCESS : IDLE;
          r_wait  <= '0;
        end
        ACCESS: if (w_ready || !PSEL) r_state <= IDLE;
                else r_wait <= r_wait + 2'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
  apb_mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .i_clk   (PCLK),
    .i_rst_n (PRESET_N),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: four configurations on one bus, scoreboard checked at every PREADY
module tb_apb_slave_mem;
  typedef struct {int d; logic [7:0] rd; logic err;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwakeup = 1'b1;
  logic       pwrite = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic       psel [4];
  logic       penable [4];
  logic [7:0] prdata [4];
  logic       pready [4];
  logic       prot_err [4];
  exp_t       sb [$];
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  apb_slave_mem #(.WAIT_STATES(0), .MEM_DEPTH(256)) u0 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite), .PWAKEUP(pwakeup), .PWDATA(pwdata), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .ERR_CLR(err_clr), .PROT_ERR(prot_err[0]));
  apb_slave_mem #(.WAIT_STATES(3), .MEM_DEPTH(256)) u1 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite), .PWAKEUP(pwakeup), .PWDATA(pwdata), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .ERR_CLR(err_clr), .PROT_ERR(prot_err[1]));
  apb_slave_mem #(.WAIT_STATES(2), .MEM_DEPTH(256)) u2 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable[2]),
    .PWRITE(pwrite), .PWAKEUP(pwakeup), .PWDATA(pwdata), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .ERR_CLR(err_clr), .PROT_ERR(prot_err[2]));
  apb_slave_mem #(.WAIT_STATES(0), .MEM_DEPTH(16)) u3 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr), .PSEL(psel[3]), .PENABLE(penable[3]),
    .PWRITE(pwrite), .PWAKEUP(pwakeup), .PWDATA(pwdata), .PRDATA(prdata[3]),
    .PREADY(pready[3]), .ERR_CLR(err_clr), .PROT_ERR(prot_err[3]));
  task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  // one transfer; the monitor checks the PREADY-cycle response, this task checks latency
  task automatic xfer(int d, bit wr, logic [7:0] a, logic [7:0] wd, logic [7:0] exp_rd, bit exp_err, bit glitch);
    int n = 0;
    int ws = d == 1 ? 3 : d == 2 ? 2 : 0;
    psel[d] = 1'b1; penable[d] = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    sb.push_back('{d, exp_rd, exp_err});
    @(posedge clk); #1 penable[d] = 1'b1;
    do begin
      @(negedge clk); n++;
      if (!pready[d]) chk("prdata_not_ready", prdata[d], 8'h00);
      if (glitch && n == 2) paddr = a + 8'd1;
    end while (!pready[d] && n < 12);
    chk("latency", 8'(n), 8'(2 + ws));
    @(posedge clk); #1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < 4; i++) begin psel[i] = 1'b0; penable[i] = 1'b0; end
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) if (pready[d]) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected_pready dut=%0d actual=1 required=0", d);
      end else begin
        e = sb.pop_front();
        chk("sb_dut", 8'(d), 8'(e.d));
        chk("sb_prdata", prdata[d], e.rd);
        chk("sb_prot_err", 8'(prot_err[d]), 8'(e.err));
      end
    end
  end
  initial begin
    for (int i = 0; i < 4; i++) begin psel[i] = 1'b0; penable[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_pready", 8'(pready[d]), 8'h00);
      chk("rst_prdata", prdata[d], 8'h00);
      chk("rst_prot_err", 8'(prot_err[d]), 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;
    xfer(0, 1, 8'h10, 8'hA5, 8'h00, 0, 0);
    xfer(0, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    xfer(0, 1, 8'h00, 8'h01, 8'h00, 0, 0);
    xfer(0, 1, 8'hFF, 8'h02, 8'h00, 0, 0);
    xfer(0, 0, 8'h00, 8'h00, 8'h01, 0, 0);
    xfer(0, 0, 8'hFF, 8'h00, 8'h02, 0, 0);
    idle(1);
    pwakeup = 1'b0; psel[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("no_wakeup_err", 8'(prot_err[0]), 8'h00);
    psel[0] = 1'b0; pwakeup = 1'b1;
    penable[0] = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1 chk("set_wins", 8'(prot_err[0]), 8'h01);
    penable[0] = 1'b0;
    @(posedge clk); #1 chk("err_clr", 8'(prot_err[0]), 8'h00);
    err_clr = 1'b0;
    psel[0] = 1'b1; paddr = 8'h10; pwrite = 1'b0;
    @(posedge clk); #1 psel[0] = 1'b0;
    @(posedge clk); #1 chk("setup_no_enable", 8'(prot_err[0]), 8'h01);
    xfer(0, 0, 8'h10, 8'h00, 8'hA5, 1, 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_clr2", 8'(prot_err[0]), 8'h00);
    xfer(1, 1, 8'h10, 8'hA5, 8'h00, 0, 0);
    xfer(1, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    xfer(2, 1, 8'h10, 8'h3C, 8'h00, 1, 1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("glitch_clr", 8'(prot_err[2]), 8'h00);
    xfer(2, 0, 8'h10, 8'h00, 8'h3C, 0, 0);
    xfer(2, 0, 8'h11, 8'h00, 8'h00, 0, 0);
    xfer(3, 1, 8'h20, 8'h77, 8'h00, 0, 0);
    xfer(3, 0, 8'h20, 8'h00, 8'h00, 0, 0);
    xfer(3, 1, 8'h05, 8'h66, 8'h00, 0, 0);
    xfer(3, 0, 8'h05, 8'h00, 8'h66, 0, 0);
    xfer(1, 1, 8'h20, 8'h11, 8'h00, 0, 0);
    idle(1);
    penable[1] = 1'b1;
    @(posedge clk); #1 penable[1] = 1'b0;
    psel[1] = 1'b1; paddr = 8'h20; pwrite = 1'b1; pwdata = 8'h5A;
    @(posedge clk); #1 penable[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_prot_err", 8'(prot_err[1]), 8'h01);
    rst_n = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    #1;
    chk("async_rst_pready", 8'(pready[1]), 8'h00);
    chk("async_rst_prdata", prdata[1], 8'h00);
    chk("async_rst_prot_err", 8'(prot_err[1]), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    xfer(1, 0, 8'h20, 8'h00, 8'h00, 0, 0);
    xfer(0, 0, 8'h10, 8'h00, 8'h00, 0, 0);
    idle(2);
    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
